// File: rtl/riscv_32m_issue_controller.sv
// Issue controller for the pipelined RV32M ALU.
// It latches the operands, stalls the core for the latency the ALU reports, and issues a single write-back pulse.
module riscv_32m_issue_controller #(
   parameter int unsigned MAX_STALL = 15
) (
   input  logic        clock_i,
   input  logic        resetn_i,
   input  logic        issue_i,
   input  logic [2:0]  func3_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   input  logic        flush_i,
   output logic [31:0] alu_in0_o,
   output logic [31:0] alu_in1_o,
   output logic [2:0]  alu_func3_o,
   input  logic [3:0]  alu_stall_cycles_i,
   input  logic [31:0] alu_result_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

   state_t     state, state_nxt;
   logic [3:0] count, count_nxt;
   logic       entry, entry_nxt;
   logic [4:0] rd_q;
   logic [3:0] stall_clamped;
   logic [3:0] remaining;
   logic       accept;
   logic       capture;

   // The ALU latency is only valid once alu_func3_o is registered, so the
   // entry cycle works from the live report and later cycles from count.
   always_comb begin
      stall_clamped = (alu_stall_cycles_i > MAX_CNT) ? MAX_CNT : alu_stall_cycles_i;
      remaining     = entry ? stall_clamped : count;
      accept        = (state == IDLE) && issue_i && !flush_i;
      capture       = (state == EXEC) && !flush_i && (remaining == 4'd0);
   end

   // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      entry_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = EXEC;
               entry_nxt = 1'b1;
            end
         end
         EXEC: begin
            if (flush_i || remaining == 4'd0) begin
               state_nxt = IDLE;
               count_nxt = 4'd0;
            end else begin
               count_nxt = remaining - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = 4'd0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments, so every flop samples the values from before the edge.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state <= IDLE;
         count <= 4'd0;
         entry <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         entry <= entry_nxt;
      end
   end

   // The operands load only on acceptance, so they stay frozen for the whole EXEC period.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         alu_in0_o   <= '0;
         alu_in1_o   <= '0;
         alu_func3_o <= '0;
         rd_q        <= '0;
      end else if (accept) begin
         alu_in0_o   <= src1_i;
         alu_in1_o   <= src2_i;
         alu_func3_o <= func3_i;
         rd_q        <= rd_i;
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wb_valid_o <= 1'b0;
         wb_rd_o    <= '0;
         wb_data_o  <= '0;
      end else begin
         wb_valid_o <= capture && (rd_q != 5'd0);
         if (capture) begin
            wb_rd_o   <= rd_q;
            wb_data_o <= alu_result_i;
         end
      end
   end

   assign stall_o = accept || (state == EXEC);
   assign busy_o  = (state == EXEC);

endmodule

// File: tb/tb_riscv_32m_issue_controller.sv
// Directed bench for riscv_32m_issue_controller, driven by a behavioural M-ALU stub whose latency can be set per test.
module tb_riscv_32m_issue_controller;

   logic        clock_i = 1'b0;
   logic        resetn_i;
   logic        issue_i;
   logic [2:0]  func3_i;
   logic [4:0]  rd_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic        flush_i;
   logic [31:0] alu_in0_o;
   logic [31:0] alu_in1_o;
   logic [2:0]  alu_func3_o;
   logic [3:0]  alu_stall_cycles_i;
   logic [31:0] alu_result_i;
   logic        stall_o;
   logic        busy_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;

   int total = 0;
   int bad   = 0;

   logic [3:0] mul_lat = 4'd0;
   logic [3:0] div_lat = 4'd1;

   always #5 clock_i = ~clock_i;

   riscv_32m_issue_controller #(.MAX_STALL(4)) dut (
      .clock_i            (clock_i),
      .resetn_i           (resetn_i),
      .issue_i            (issue_i),
      .func3_i            (func3_i),
      .rd_i               (rd_i),
      .src1_i             (src1_i),
      .src2_i             (src2_i),
      .flush_i            (flush_i),
      .alu_in0_o          (alu_in0_o),
      .alu_in1_o          (alu_in1_o),
      .alu_func3_o        (alu_func3_o),
      .alu_stall_cycles_i (alu_stall_cycles_i),
      .alu_result_i       (alu_result_i),
      .stall_o            (stall_o),
      .busy_o             (busy_o),
      .wb_valid_o         (wb_valid_o),
      .wb_rd_o            (wb_rd_o),
      .wb_data_o          (wb_data_o)
   );

   // ALU stub: latency depends on the op class, and the result is computed from the registered operands.
   logic signed [63:0] a64, b64, p64;
   always_comb begin
      a64 = {{32{alu_in0_o[31]}}, alu_in0_o};
      b64 = {{32{alu_in1_o[31]}}, alu_in1_o};
      p64 = a64 * b64;
      alu_stall_cycles_i = alu_func3_o[2] ? div_lat : mul_lat;
      alu_result_i = 32'd0;
      case (alu_func3_o)
         3'b000: alu_result_i = p64[31:0];
         3'b001: alu_result_i = p64[63:32];
         3'b100: alu_result_i = (alu_in1_o == 0) ? 32'hffff_ffff : 32'($signed(alu_in0_o) / $signed(alu_in1_o));
         3'b110: alu_result_i = (alu_in1_o == 0) ? alu_in0_o : 32'($signed(alu_in0_o) % $signed(alu_in1_o));
         default: alu_result_i = 32'd0;
      endcase
   end

   task automatic cyc();
      @(posedge clock_i);
      #1;
   endtask

   task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      issue_i = 1'b1;
      func3_i = f3;
      src1_i  = a;
      src2_i  = b;
      rd_i    = rd;
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      issue_i  = 1'b0;
      func3_i  = '0;
      rd_i     = '0;
      src1_i   = '0;
      src2_i   = '0;
      flush_i  = 1'b0;
      #3;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid_o); end
      total++; if ({alu_in0_o, alu_in1_o, alu_func3_o} !== 67'd0) begin bad++;
         $display("FAIL reset_alu_regs got=%h/%h/%h exp=0", alu_in0_o, alu_in1_o, alu_func3_o); end
      total++; if ({wb_rd_o, wb_data_o} !== 37'd0) begin bad++;
         $display("FAIL reset_wb_regs got=%h/%h exp=0", wb_rd_o, wb_data_o); end
      cyc();
      cyc();
      resetn_i = 1'b1;
      cyc();
   endtask

   task automatic test_mul_latency();
      mul_lat = 4'd0;
      drive_op(3'b000, 32'd7, 32'd6, 5'd5);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) issue_i = 1'b0;
         @(negedge clock_i);
         total++; if (stall_o !== (c <= 1)) begin bad++; $display("FAIL mul_stall c=%0d got=%b exp=%b", c, stall_o, c <= 1); end
         total++; if (wb_valid_o !== (c == 2)) begin bad++; $display("FAIL mul_wb_valid c=%0d got=%b exp=%b", c, wb_valid_o, c == 2); end
         if (c == 1) begin
            total++; if (busy_o !== 1'b1 || alu_in0_o !== 32'd7 || alu_in1_o !== 32'd6 || alu_func3_o !== 3'b000) begin bad++;
               $display("FAIL mul_operands busy=%b in0=%0d in1=%0d f3=%b exp=1/7/6/000", busy_o, alu_in0_o, alu_in1_o, alu_func3_o); end
         end
         if (c >= 2) begin
            total++; if (wb_rd_o !== 5'd5 || wb_data_o !== 32'd42) begin bad++;
               $display("FAIL mul_wb_data c=%0d rd=%0d data=%0d exp=5/42", c, wb_rd_o, wb_data_o); end
         end
         cyc();
      end
   endtask

   task automatic test_div_latency();
      logic [2:0]  f3s [2];
      logic [31:0] exps [2];
      f3s  = '{3'b100, 3'b110};
      exps = '{32'd14, 32'd2};
      div_lat = 4'd1;
      for (int k = 0; k < 2; k++) begin
         drive_op(f3s[k], 32'd100, 32'd7, 5'd9);
         for (int c = 0; c < 5; c++) begin
            if (c == 1) issue_i = 1'b0;
            @(negedge clock_i);
            total++; if (stall_o !== (c <= 2)) begin bad++; $display("FAIL div_stall k=%0d c=%0d got=%b exp=%b", k, c, stall_o, c <= 2); end
            total++; if (wb_valid_o !== (c == 3)) begin bad++; $display("FAIL div_wb_valid k=%0d c=%0d got=%b exp=%b", k, c, wb_valid_o, c == 3); end
            if (c == 3) begin
               total++; if (wb_rd_o !== 5'd9 || wb_data_o !== exps[k]) begin bad++;
                  $display("FAIL div_wb_data k=%0d rd=%0d data=%0d exp=9/%0d", k, wb_rd_o, wb_data_o, exps[k]); end
            end
            cyc();
         end
      end
   endtask

   task automatic test_stall_clamp();
      logic [3:0] lats [2];
      int         ns [2];
      lats = '{4'd15, 4'd3};
      ns   = '{4, 3};
      for (int k = 0; k < 2; k++) begin
         mul_lat = lats[k];
         drive_op(3'b000, 32'd7, 32'd6, 5'd5);
         for (int c = 0; c < ns[k] + 4; c++) begin
            if (c == 1) begin
               issue_i = 1'b0;
               src1_i  = 32'hdead_beef;
               src2_i  = 32'h1234_5678;
            end
            @(negedge clock_i);
            total++; if (stall_o !== (c <= ns[k] + 1)) begin bad++;
               $display("FAIL clamp_stall k=%0d c=%0d got=%b exp=%b", k, c, stall_o, c <= ns[k] + 1); end
            total++; if (wb_valid_o !== (c == ns[k] + 2)) begin bad++;
               $display("FAIL clamp_wb_valid k=%0d c=%0d got=%b exp=%b", k, c, wb_valid_o, c == ns[k] + 2); end
            if (c >= 1 && c <= ns[k] + 1) begin
               total++; if (alu_in0_o !== 32'd7 || alu_in1_o !== 32'd6) begin bad++;
                  $display("FAIL clamp_operand_hold c=%0d in0=%h in1=%h exp=7/6", c, alu_in0_o, alu_in1_o); end
            end
            cyc();
         end
      end
      mul_lat = 4'd0;
   endtask

   task automatic test_flush();
      div_lat = 4'd1;
      mul_lat = 4'd0;
      // A flush in IDLE must block acceptance.
      drive_op(3'b000, 32'd5, 32'd5, 5'd4);
      flush_i = 1'b1;
      @(negedge clock_i);
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall_o); end
      cyc();
      issue_i = 1'b0;
      flush_i = 1'b0;
      @(negedge clock_i);
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", busy_o); end
      cyc();
      // Here the divide is aborted by a flush one cycle after it is issued.
      drive_op(3'b100, 32'd100, 32'd7, 5'd9);
      cyc();
      issue_i = 1'b0;
      flush_i = 1'b1;
      @(negedge clock_i);
      total++; if (stall_o !== 1'b1 || busy_o !== 1'b1) begin bad++;
         $display("FAIL flush_exec stall=%b busy=%b exp=1/1", stall_o, busy_o); end
      cyc();
      flush_i = 1'b0;
      total++; if (stall_o !== 1'b0 || busy_o !== 1'b0) begin bad++;
         $display("FAIL flush_abort stall=%b busy=%b exp=0/0", stall_o, busy_o); end
      drive_op(3'b000, 32'd3, 32'd3, 5'd3);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) issue_i = 1'b0;
         @(negedge clock_i);
         total++; if (stall_o !== (c <= 1)) begin bad++; $display("FAIL flush_next_stall c=%0d got=%b exp=%b", c, stall_o, c <= 1); end
         total++; if (wb_valid_o !== (c == 2)) begin bad++; $display("FAIL flush_wb_valid c=%0d got=%b exp=%b", c, wb_valid_o, c == 2); end
         if (c == 2) begin
            total++; if (wb_rd_o !== 5'd3 || wb_data_o !== 32'd9) begin bad++;
               $display("FAIL flush_next_data rd=%0d data=%0d exp=3/9", wb_rd_o, wb_data_o); end
         end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      mul_lat = 4'd0;
      drive_op(3'b000, 32'd2, 32'd3, 5'd1);
      cyc();
      issue_i = 1'b0;
      cyc();
      // The first op writes back in this cycle, and the mulh is issued in the same cycle.
      drive_op(3'b001, 32'h4000_0000, 32'd8, 5'd2);
      @(negedge clock_i);
      total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd1 || wb_data_o !== 32'd6) begin bad++;
         $display("FAIL b2b_first valid=%b rd=%0d data=%0d exp=1/1/6", wb_valid_o, wb_rd_o, wb_data_o); end
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_issue_stall got=%b exp=1", stall_o); end
      cyc();
      issue_i = 1'b0;
      @(negedge clock_i);
      total++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b1 || alu_func3_o !== 3'b001) begin bad++;
         $display("FAIL b2b_gap valid=%b busy=%b f3=%b exp=0/1/001", wb_valid_o, busy_o, alu_func3_o); end
      cyc();
      @(negedge clock_i);
      total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd2 || wb_data_o !== 32'd2) begin bad++;
         $display("FAIL b2b_second valid=%b rd=%0d data=%0d exp=1/2/2", wb_valid_o, wb_rd_o, wb_data_o); end
      cyc();
      // With rd=0 the stall profile is unchanged, but no write-back pulse is issued.
      drive_op(3'b000, 32'd4, 32'd5, 5'd0);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) issue_i = 1'b0;
         @(negedge clock_i);
         total++; if (stall_o !== (c <= 1)) begin bad++; $display("FAIL rd0_stall c=%0d got=%b exp=%b", c, stall_o, c <= 1); end
         total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rd0_wb_valid c=%0d got=%b exp=0", c, wb_valid_o); end
         cyc();
      end
   endtask

   task automatic test_async_reset();
      div_lat = 4'd3;
      drive_op(3'b100, 32'd100, 32'd7, 5'd9);
      cyc();
      issue_i = 1'b0;
      cyc();
      @(negedge clock_i);
      #2;
      resetn_i = 1'b0;
      #1;
      total++; if (stall_o !== 1'b0 || busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin bad++;
         $display("FAIL arst_ctrl stall=%b busy=%b valid=%b exp=0/0/0", stall_o, busy_o, wb_valid_o); end
      total++; if ({alu_in0_o, alu_in1_o, alu_func3_o, wb_rd_o, wb_data_o} !== 104'd0) begin bad++;
         $display("FAIL arst_regs in0=%h in1=%h f3=%h rd=%h data=%h exp=0", alu_in0_o, alu_in1_o, alu_func3_o, wb_rd_o, wb_data_o); end
      cyc();
      resetn_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock_i);
         total++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++;
            $display("FAIL arst_after c=%0d valid=%b busy=%b exp=0/0", c, wb_valid_o, busy_o); end
         cyc();
      end
      drive_op(3'b000, 32'd7, 32'd6, 5'd5);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) issue_i = 1'b0;
         @(negedge clock_i);
         total++; if (stall_o !== (c <= 1)) begin bad++; $display("FAIL arst_mul_stall c=%0d got=%b exp=%b", c, stall_o, c <= 1); end
         total++; if (wb_valid_o !== (c == 2)) begin bad++; $display("FAIL arst_mul_valid c=%0d got=%b exp=%b", c, wb_valid_o, c == 2); end
         if (c == 2) begin
            total++; if (wb_rd_o !== 5'd5 || wb_data_o !== 32'd42) begin bad++;
               $display("FAIL arst_mul_data rd=%0d data=%0d exp=5/42", wb_rd_o, wb_data_o); end
         end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_mul_latency();
      test_div_latency();
      test_stall_clamp();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
